// File: rtl/lfsr_bert_ctrl.sv
// lfsr_bert_ctrl: BER test sequencer for the 8-bit LFSR generator/checker pair.
// Flow: seed load + generator reset, wait for checker lock, fixed-length run,
// then report a saturating mismatch count and pass/fail.
//
// Optional feature macro: BERT_LOCK_LOSS_ABORT_EN
//   defined   : checker lock loss during RUN ends the test in FAIL
//   undefined : lock is ignored in RUN; the window always runs full length
//
// Ports:
//   clk, i_rst          clock, synchronous active-high reset
//   i_start, i_abort    start/restart (IDLE/DONE/FAIL only), abort to IDLE
//   i_seed, i_test_len  captured on an accepted start
//   i_lock, i_err       checker lock and per-cycle mismatch flag
//   o_gen_rst, o_seed   generator/checker reset and seed to load
//   o_gen_en            generator advance enable
//   o_busy, o_done      LOAD/SYNC/RUN, DONE/FAIL levels
//   o_pass, o_err_cnt   result, saturating error count
//   o_state             IDLE=0 LOAD=1 SYNC=2 RUN=3 DONE=4 FAIL=5
module lfsr_bert_ctrl #(
    parameter int LEN_W        = 16,
    parameter int ERR_W        = 16,
    parameter int SYNC_TIMEOUT = 64,
    parameter int RST_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [7:0]       i_seed,
    input  logic [LEN_W-1:0] i_test_len,
    input  logic             i_lock,
    input  logic             i_err,
    output logic             o_gen_rst,
    output logic [7:0]       o_seed,
    output logic             o_gen_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SYNC = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4,
        S_FAIL = 3'd5
    } state_t;

    localparam logic [LEN_W-1:0] RST_LAST  = LEN_W'(RST_CYCLES - 1);
    localparam logic [LEN_W-1:0] SYNC_LAST = LEN_W'(SYNC_TIMEOUT - 1);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

    state_t           state;
    state_t           state_d;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_last;
    logic [ERR_W-1:0] err_d;
    logic [ERR_W-1:0] err_run;
    logic             idle_like;
    logic             start_ok;

    assign len_last  = len_q - ONE;
    assign idle_like = (state == S_IDLE) || (state == S_DONE) ||
                       (state == S_FAIL);
    assign start_ok  = i_start && !i_abort && idle_like;

    // Saturating increment: the count sticks at all-ones.
    assign err_run = (i_err && !(&o_err_cnt)) ? o_err_cnt + ERR_ONE
                                              : o_err_cnt;

    // One counter serves as LOAD length, SYNC timer and RUN cycle count.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        err_d   = o_err_cnt;
        if (i_abort && state != S_IDLE) begin
            state_d = S_IDLE;
        end else if (start_ok) begin
            err_d   = '0;
            cnt_d   = '0;
            state_d = (i_test_len == '0) ? S_DONE : S_LOAD;
        end else begin
            case (state)
                S_LOAD: begin
                    if (cnt == RST_LAST) begin
                        cnt_d   = '0;
                        state_d = S_SYNC;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
                end
                S_SYNC: begin
                    // Lock wins over a same-cycle timeout.
                    if (i_lock) begin
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else if (cnt == SYNC_LAST) begin
                        state_d = S_FAIL;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
                end
                S_RUN: begin
                    err_d = err_run;
`ifdef BERT_LOCK_LOSS_ABORT_EN
                    if (!i_lock) begin
                        state_d = S_FAIL;
                    end else if (cnt == len_last) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
`else
                    if (cnt == len_last) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt + ONE;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            len_q     <= '0;
            o_seed    <= '0;
            o_err_cnt <= '0;
            o_state   <= '0;
            o_gen_rst <= 1'b0;
            o_gen_en  <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_pass    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            o_err_cnt <= err_d;
            if (start_ok) begin
                o_seed <= i_seed;
                len_q  <= i_test_len;
            end
            o_state   <= state_d;
            o_gen_rst <= (state_d == S_LOAD);
            o_gen_en  <= (state_d == S_SYNC) || (state_d == S_RUN);
            o_busy    <= (state_d == S_LOAD) || (state_d == S_SYNC) ||
                         (state_d == S_RUN);
            o_done    <= (state_d == S_DONE) || (state_d == S_FAIL);
            o_pass    <= (state_d == S_DONE) && (err_d == '0);
        end
    end

endmodule

// File: tb/tb_lfsr_bert_ctrl.sv
// tb_lfsr_bert_ctrl: directed test of the BER sequencer against a
// phase/countdown model, plus hand-computed literal expectations.
module tb_lfsr_bert_ctrl;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [7:0]  i_seed = 8'h00;
    logic [15:0] i_test_len = 16'd0;
    logic        i_lock = 1'b0;
    logic        i_err = 1'b0;

    logic        o_gen_rst, o_gen_en, o_busy, o_done, o_pass;
    logic [7:0]  o_seed;
    logic [15:0] o_err_cnt;
    logic [2:0]  o_state;

    logic        d4_gen_rst, d4_gen_en, d4_busy, d4_done, d4_pass;
    logic [7:0]  d4_seed;
    logic [3:0]  d4_err_cnt;
    logic [2:0]  d4_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_bert_ctrl u_dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_abort(i_abort), .i_seed(i_seed),
        .i_test_len(i_test_len), .i_lock(i_lock),
        .i_err(i_err), .o_gen_rst(o_gen_rst),
        .o_seed(o_seed), .o_gen_en(o_gen_en),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
        .o_err_cnt(o_err_cnt), .o_state(o_state)
    );

    lfsr_bert_ctrl #(.ERR_W(4)) u_dut4 (
        .clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_abort(i_abort), .i_seed(i_seed),
        .i_test_len(i_test_len), .i_lock(i_lock),
        .i_err(i_err), .o_gen_rst(d4_gen_rst),
        .o_seed(d4_seed), .o_gen_en(d4_gen_en),
        .o_busy(d4_busy), .o_done(d4_done), .o_pass(d4_pass),
        .o_err_cnt(d4_err_cnt), .o_state(d4_state)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h required=%0h",
                     name, $time, act, exp);
        end
    endtask

    // Model: phase number, cycles left in the phase, raw error total.
    int m_ph = 0, m_left = 0, m_err = 0, m_len = 0, m_seed = 0;

    initial forever begin
        logic [31:0] exp_v, act_v;
        logic [4:0]  exp4, act4;
        int          e16, e4;
        @(posedge clk);
        #1;
        if (i_rst) begin
            m_ph = 0; m_left = 0; m_err = 0; m_len = 0; m_seed = 0;
        end else if (i_abort && m_ph != 0) begin
            m_ph = 0;
        end else if (i_start && !i_abort &&
                     (m_ph == 0 || m_ph == 4 || m_ph == 5)) begin
            m_seed = i_seed;
            m_len  = i_test_len;
            m_err  = 0;
            if (m_len == 0) m_ph = 4;
            else begin m_ph = 1; m_left = 2; end
        end else if (m_ph == 1) begin
            m_left--;
            if (m_left == 0) begin m_ph = 2; m_left = 64; end
        end else if (m_ph == 2) begin
            if (i_lock) begin m_ph = 3; m_left = m_len; end
            else begin
                m_left--;
                if (m_left == 0) m_ph = 5;
            end
        end else if (m_ph == 3) begin
            m_err += int'(i_err);
            m_left--;
`ifdef BERT_LOCK_LOSS_ABORT_EN
            if (!i_lock) m_ph = 5;
            else if (m_left == 0) m_ph = 4;
`else
            if (m_left == 0) m_ph = 4;
`endif
        end
        e16 = (m_err > 65535) ? 65535 : m_err;
        e4  = (m_err > 15) ? 15 : m_err;
        exp_v = {3'(m_ph), m_ph == 1, m_ph == 2 || m_ph == 3,
                 m_ph >= 1 && m_ph <= 3, m_ph >= 4,
                 m_ph == 4 && m_err == 0, 8'(m_seed), 16'(e16)};
        act_v = {o_state, o_gen_rst, o_gen_en, o_busy, o_done,
                 o_pass, o_seed, o_err_cnt};
        chk("cycle_outputs", 64'(act_v), 64'(exp_v));
        exp4 = {4'(e4), m_ph == 4 && m_err == 0};
        act4 = {d4_err_cnt, d4_pass};
        chk("cycle_err4", 64'(act4), 64'(exp4));
    end

    int load_c, sync_c, run_c, first_st, first_err;

    task automatic run_test(input logic [7:0] seed, input int len,
                            input int lock_dly, input logic [31:0] mask,
                            input int drop_at, input int abort_at);
        int sidx, ridx;
        bit ended;
        load_c = 0; sync_c = 0; run_c = 0;
        sidx = 0; ridx = 0; ended = 0;
        @(negedge clk);
        i_seed = seed;
        i_test_len = 16'(len);
        i_start = 1'b1;
        for (int c = 0; c < 400 && !ended; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            i_abort = 1'b0;
            i_err = 1'b0;
            if (c == 0) begin
                first_st = int'(o_state);
                first_err = int'(o_err_cnt);
            end
            case (o_state)
                3'd1: load_c++;
                3'd2: begin
                    i_lock = (sidx >= lock_dly);
                    sidx++; sync_c++;
                end
                3'd3: begin
                    i_err = (ridx < 32) ? mask[ridx] : 1'b0;
                    i_lock = !(drop_at >= 0 && ridx >= drop_at);
                    if (ridx == abort_at) begin
                        i_abort = 1'b1; i_start = 1'b1;
                    end
                    ridx++; run_c++;
                end
                default: ended = 1;
            endcase
        end
        chk("run_ended", 64'(ended), 64'd1);
        i_lock = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", 64'(o_state), 64'd0);
        chk("rst_err", 64'(o_err_cnt), 64'd0);
        chk("rst_outs", 64'({o_gen_rst, o_gen_en, o_busy, o_done,
                             o_pass}), 64'd0);
        i_rst = 1'b0;
        @(negedge clk);

        run_test(8'h5A, 10, 3, 32'h0, -1, -1);
        chk("t1_load_cyc", 64'(load_c), 64'd2);
        chk("t1_sync_cyc", 64'(sync_c), 64'd4);
        chk("t1_run_cyc", 64'(run_c), 64'd10);
        chk("t1_state", 64'(o_state), 64'd4);
        chk("t1_pass", 64'(o_pass), 64'd1);
        chk("t1_seed", 64'(o_seed), 64'h5A);

        run_test(8'hC3, 10, 3, 32'h224, -1, -1);
        chk("t2_err", 64'(o_err_cnt), 64'd3);
        chk("t2_pass", 64'(o_pass), 64'd0);
        chk("t2_state", 64'(o_state), 64'd4);

        run_test(8'h11, 10, 1000, 32'h0, -1, -1);
        chk("t3_sync_cyc", 64'(sync_c), 64'd64);
        chk("t3_state", 64'(o_state), 64'd5);
        chk("t3_gen_en", 64'(o_gen_en), 64'd0);
        chk("t3_done_pass", 64'({o_done, o_pass}), 64'b10);

        run_test(8'h22, 10, 0, 32'h6, -1, 5);
        chk("t4_run_cyc", 64'(run_c), 64'd6);
        chk("t4_state", 64'(o_state), 64'd0);
        chk("t4_err_held", 64'(o_err_cnt), 64'd2);
        chk("t4_en_done", 64'({o_gen_en, o_done}), 64'd0);

        run_test(8'h33, 0, 0, 32'h0, -1, -1);
        chk("t5_first", 64'(first_st), 64'd4);
        chk("t5_pass", 64'(o_pass), 64'd1);
        chk("t5_err", 64'(o_err_cnt), 64'd0);

        run_test(8'h44, 4, 0, 32'h1, -1, -1);
        chk("t5b_first", 64'(first_st), 64'd1);
        chk("t5b_first_err", 64'(first_err), 64'd0);
        chk("t5b_run_cyc", 64'(run_c), 64'd4);
        chk("t5b_err", 64'(o_err_cnt), 64'd1);

        run_test(8'h55, 10, 0, 32'h0, 4, -1);
`ifdef BERT_LOCK_LOSS_ABORT_EN
        chk("t6_state", 64'(o_state), 64'd5);
        chk("t6_run_cyc", 64'(run_c), 64'd5);
`else
        chk("t6_state", 64'(o_state), 64'd4);
        chk("t6_run_cyc", 64'(run_c), 64'd10);
        chk("t6_pass", 64'(o_pass), 64'd1);
`endif

        run_test(8'h66, 20, 0, 32'hFFFFF, -1, -1);
        chk("t6b_err16", 64'(o_err_cnt), 64'd20);
        chk("t6b_err4", 64'(d4_err_cnt), 64'd15);

        @(negedge clk);
        i_seed = 8'h77;
        i_test_len = 16'd10;
        i_lock = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t7_in_run", 64'(o_state), 64'd3);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        i_lock = 1'b0;
        chk("t7_state", 64'(o_state), 64'd0);
        chk("t7_seed", 64'(o_seed), 64'd0);
        chk("t7_outs", 64'({o_gen_rst, o_gen_en, o_busy, o_done,
                            o_pass}), 64'd0);
        repeat (2) @(negedge clk);
        chk("t7_no_rst_pulse", 64'(o_gen_rst), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
